me_search_ctrl: RTL
===================

Name: me_search_ctrl

Overview:
- Sequences a full-search integer motion estimation over a square window for one 32x32 CU.
- Issues one candidate MV per cycle to the reference-fetch / abs-diff front end that feeds the SAD tree.
- Aligns the returning SADs with their MVs through an internal delay line.
- Tracks the minimum SAD and best MV for the 32x32 partition and each of the four 16x16 partitions; reports them with a done pulse.

Parameters:
- SR, 8: search range; candidate MV components span -SR..SR-1, giving (2*SR)^2 candidates.
- LAT, 2: cycles from cand_valid sampled high to the corresponding SADs being valid at the inputs (abs-diff stage plus SAD tree register).
- MVW, 6: signed MV component width; must hold -SR..SR-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin search; honoured only in IDLE
- stall  in  1  front end not ready; no candidate issued this cycle
- cand_valid  out  1  candidate MV presented this cycle
- cand_mvx  out  MVW  candidate horizontal MV, signed
- cand_mvy  out  MVW  candidate vertical MV, signed
- sad32x32  in  18  SAD of the 32x32 block for the candidate issued LAT cycles earlier
- sad16x16  in  64  four 16-bit SADs; [16*k+15:16*k] is the 16x16 quadrant k, k=0..3
- best_sad32  out  18  minimum 32x32 SAD
- best_mv32  out  2*MVW  {mvy,mvx} of best_sad32
- best_sad16  out  64  minimum SAD per 16x16 quadrant, same packing as sad16x16
- best_mv16  out  8*MVW  {mvy,mvx} per quadrant; quadrant k at [2*MVW*k+2*MVW-1 : 2*MVW*k]
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; best_* are final

Behaviour:
- Reset: state IDLE; cand_valid=0; cand_mvx=cand_mvy=0; busy=0; done=0; best_sad32=all ones; best_sad16=all ones; best_mv32=0; best_mv16=0; delay line cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, start=1:
  - Load mvx=mvy=-SR.
  - Load all best_sad fields with all ones; best_mv fields are left unchanged.
  - Go to ISSUE.
- ISSUE:
  - cand_valid = !stall; cand_mvx/cand_mvy show the current candidate, driven registered from the counters.
  - When !stall, advance in raster order: mvx++; if mvx was SR-1, set mvx=-SR and mvy++.
  - When the issued candidate is (SR-1,SR-1), go to DRAIN.
  - When stall=1, the counters hold and cand_valid=0.
- Delay line:
  - LAT-deep shift register of {valid, mvy, mvx}.
  - Shifts every cycle regardless of stall; a stalled cycle inserts a bubble (valid=0).
  - The tail entry qualifies sad32x32 and sad16x16 in that cycle.
- Compare, on each cycle with the tail valid:
  - If sad32x32 < best_sad32, update best_sad32 and best_mv32 from the tail MV.
  - Independently, for each quadrant k: if its SAD < best_sad16[k], update best_sad16[k] and best_mv16[k].
  - Strict less-than: on ties the earliest raster candidate wins.
- DRAIN: count LAT cycles so the last valid result has been compared, then go to DONE.
- DONE: done=1 for exactly one cycle; busy=0; return to IDLE.
- busy timing: busy=1 in ISSUE and DRAIN.
- Outputs after done: best_* hold until the next accepted start.
- Timing with no stall:
  - start sampled at edge 0.
  - First cand_valid in cycle 1.
  - Last candidate in cycle N=(2*SR)^2.
  - Last compare in cycle N+LAT.
  - done in cycle N+LAT+1.
- start while busy or in DONE: ignored; the search is not restarted.
- stall during DRAIN: no effect.
- Reset asserted mid-search: immediate return to reset values; no done is produced.
- Arithmetic: SADs are compared unsigned; MVs are two's complement of width MVW.

Test Plan:
- SR=8, LAT=2, all SAD inputs constant 100, no stall -> 256 cand_valid cycles in raster order from (-8,-8) to (7,7); done in cycle 259; best_sad32=100; best_mv32 and every best_mv16 = (-8,-8).
- sad32x32 = 500 except 37 at candidate (mvx=3, mvy=-2); quadrant k minimum 10+k at distinct candidates -> best_mv32=(3,-2), best_sad32=37; each best_mv16[k] matches its injected position.
- Random stall at 30% with the same minimum pattern -> identical best_* results; no candidate skipped or duplicated; done delayed by exactly the number of stalled ISSUE cycles.
- Equal minimum 20 at candidates (-5,0) and (4,6) -> best_mv32=(-5,0).
- start pulsed again in cycle 100 of a search -> ignored; a single done pulse; results unchanged versus the no-restart run.
- rst_n low in cycle 50, released, then a new start -> all outputs at reset values during reset; no done from the aborted search; the new search completes correctly.

Source files
------------

// File: rtl/me_search_ctrl.sv
// me_search_ctrl: full-search integer motion estimation sequencer for one 32x32 CU,
// issuing raster-order candidate MVs and tracking the best 32x32 / 16x16 SADs.
module me_search_ctrl #(
    parameter int SR  = 8,
    parameter int LAT = 2,
    parameter int MVW = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stall,
    output logic                 cand_valid,
    output logic [MVW-1:0]       cand_mvx,
    output logic [MVW-1:0]       cand_mvy,
    input  logic [17:0]          sad32x32,
    input  logic [63:0]          sad16x16,
    output logic [17:0]          best_sad32,
    output logic [2*MVW-1:0]     best_mv32,
    output logic [63:0]          best_sad16,
    output logic [8*MVW-1:0]     best_mv16,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    localparam int CW = $clog2(LAT + 1);
    localparam logic [MVW-1:0] MV_MIN = MVW'(-SR);
    localparam logic [MVW-1:0] MV_MAX = MVW'(SR - 1);

    state_t           state, state_nx;
    logic [MVW-1:0]   mvx, mvy;
    logic [CW-1:0]    drain_cnt;
    logic             dl_v  [LAT];
    logic [2*MVW-1:0] dl_mv [LAT];
    logic             last, accept;

    assign cand_mvx = mvx;
    assign cand_mvy = mvy;
    assign last     = (mvx == MV_MAX) && (mvy == MV_MAX);
    assign accept   = (state == IDLE) && start;

    always_comb begin
        state_nx   = state;
        cand_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  state_nx = start ? ISSUE : IDLE;
            ISSUE: begin
                busy       = 1'b1;
                cand_valid = !stall;
                state_nx   = (!stall && last) ? DRAIN : ISSUE;
            end
            DRAIN: begin
                busy     = 1'b1;
                state_nx = (drain_cnt == CW'(LAT - 1)) ? DONE : DRAIN;
            end
            default: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mvx       <= '0;
            mvy       <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= (state == DRAIN) ? drain_cnt + CW'(1) : '0;
            if (accept) begin
                mvx <= MV_MIN;
                mvy <= MV_MIN;
            end else if (cand_valid) begin
                mvx <= (mvx == MV_MAX) ? MV_MIN : mvx + MVW'(1);
                mvy <= (mvx == MV_MAX) ? mvy + MVW'(1) : mvy;
            end
        end
    end

    // Stalled cycles enter the delay line as bubbles so SADs stay aligned with their MVs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                dl_v[i]  <= 1'b0;
                dl_mv[i] <= '0;
            end
        end else begin
            dl_v[0]  <= cand_valid;
            dl_mv[0] <= {mvy, mvx};
            for (int i = 1; i < LAT; i++) begin
                dl_v[i]  <= dl_v[i-1];
                dl_mv[i] <= dl_mv[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sad32 <= '1;
            best_sad16 <= '1;
            best_mv32  <= '0;
            best_mv16  <= '0;
        end else if (accept) begin
            best_sad32 <= '1;
            best_sad16 <= '1;
        end else if (dl_v[LAT-1]) begin
            if (sad32x32 < best_sad32) begin
                best_sad32 <= sad32x32;
                best_mv32  <= dl_mv[LAT-1];
            end
            for (int k = 0; k < 4; k++) begin
                if (sad16x16[16*k +: 16] < best_sad16[16*k +: 16]) begin
                    best_sad16[16*k +: 16]       <= sad16x16[16*k +: 16];
                    best_mv16[2*MVW*k +: 2*MVW] <= dl_mv[LAT-1];
                end
            end
        end
    end
endmodule
